// File: rtl/regfile_sb_if.sv
// Register file bus: write ports A/B, scoreboard set, two read ports,
// collision pulse and display tap, bundled between datapath and regfile.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DISP_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ld_wr_en;
  logic [ADDR_W-1:0] ld_wr_addr;
  logic [DATA_W-1:0] ld_wr_data;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              stall;
  logic              wr_collide;
  logic [DISP_W-1:0] disp;

  // Datapath side: drives writes, scoreboard set and read addresses
  modport master (
    output wr_en, wr_addr, wr_data,
    output ld_wr_en, ld_wr_addr, ld_wr_data,
    output busy_set, busy_addr, rs, rt,
    input  rs_data, rt_data, rs_busy, rt_busy, stall, wr_collide, disp
  );

  // Register file side
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  ld_wr_en, ld_wr_addr, ld_wr_data,
    input  busy_set, busy_addr, rs, rt,
    output rs_data, rt_data, rs_busy, rt_busy, stall, wr_collide, disp
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports (ALU and load writeback),
// optional write-to-read bypass, pending-load scoreboard with stall output,
// collision flag and a registered display tap. Register 0 is hardwired zero.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int DISP_REG = 15,
  parameter int DISP_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DISP_IDX = ADDR_W'(DISP_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              collide_q;
  logic [DISP_W-1:0] disp_q;

  logic              wr_a_hit;
  logic              wr_b_hit;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              rs_pend;
  logic              rt_pend;

  // A write only lands when its port is enabled and it targets a nonzero register
  assign wr_a_hit = bus.wr_en    && (bus.wr_addr    != '0);
  assign wr_b_hit = bus.ld_wr_en && (bus.ld_wr_addr != '0);

  // Storage: port B is applied last so a load wins over an ALU write to the same register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_a_hit) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      if (wr_b_hit) begin
        regs[bus.ld_wr_addr] <= bus.ld_wr_data;
      end
    end
  end

  // Scoreboard: a load writeback clears its bit, a new load issue sets it and wins a tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.busy_set && (bus.busy_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (bus.ld_wr_en && (bus.ld_wr_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
      busy[0] <= 1'b0;
    end
  end

  // Collision pulse and display tap are both one-cycle-late views of the previous edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collide_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      collide_q <= wr_a_hit && wr_b_hit && (bus.wr_addr == bus.ld_wr_addr);
      disp_q    <= regs[DISP_IDX][DISP_W-1:0];
    end
  end

  // Read value for one port: load data beats ALU data beats stored value when bypassing
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              a_hit,
    input logic [ADDR_W-1:0] a_addr,
    input logic [DATA_W-1:0] a_data,
    input logic              b_hit,
    input logic [ADDR_W-1:0] b_addr,
    input logic [DATA_W-1:0] b_data
  );
    logic [DATA_W-1:0] value;
    value = stored;
    if (BYPASS != 0) begin
      if (b_hit && (b_addr == addr)) begin
        value = b_data;
      end else if (a_hit && (a_addr == addr)) begin
        value = a_data;
      end
    end
    return value;
  endfunction

  // Pending status for one port: an arriving load hides the busy bit when bypassing
  function automatic logic read_busy(
    input logic [ADDR_W-1:0] addr,
    input logic              stored,
    input logic              b_en,
    input logic [ADDR_W-1:0] b_addr
  );
    logic pend;
    pend = stored;
    if ((BYPASS != 0) && b_en && (b_addr == addr)) begin
      pend = 1'b0;
    end
    return pend;
  endfunction

  // Source operand lookup; forced to zero while reset holds so nothing leaks through bypass
  always_comb begin
    rs_val  = read_value(bus.rs, regs[bus.rs], wr_a_hit, bus.wr_addr, bus.wr_data,
                         wr_b_hit, bus.ld_wr_addr, bus.ld_wr_data);
    rt_val  = read_value(bus.rt, regs[bus.rt], wr_a_hit, bus.wr_addr, bus.wr_data,
                         wr_b_hit, bus.ld_wr_addr, bus.ld_wr_data);
    rs_pend = read_busy(bus.rs, busy[bus.rs], bus.ld_wr_en, bus.ld_wr_addr);
    rt_pend = read_busy(bus.rt, busy[bus.rt], bus.ld_wr_en, bus.ld_wr_addr);
    if (!rst) begin
      rs_val  = '0;
      rt_val  = '0;
      rs_pend = 1'b0;
      rt_pend = 1'b0;
    end
  end

  assign bus.rs_data    = rs_val;
  assign bus.rt_data    = rt_val;
  assign bus.rs_busy    = rs_pend;
  assign bus.rt_busy    = rt_pend;
  assign bus.stall      = rs_pend | rt_pend;
  assign bus.wr_collide = collide_q;
  assign bus.disp       = disp_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance
// share stimulus; expected values are queued and checked at each falling edge.
module tb_regfile_sb;

  localparam int F_RS_DATA = 0;
  localparam int F_RT_DATA = 1;
  localparam int F_RS_BUSY = 2;
  localparam int F_RT_BUSY = 3;
  localparam int F_STALL   = 4;
  localparam int F_COLL    = 5;
  localparam int F_DISP    = 6;

  typedef struct {
    bit          sel;
    int          field;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        ld_wr_en = 1'b0;
  logic [3:0]  ld_wr_addr = '0;
  logic [15:0] ld_wr_data = '0;
  logic        busy_set = 1'b0;
  logic [3:0]  busy_addr = '0;
  logic [3:0]  rs = '0;
  logic [3:0]  rt = '0;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .DISP_W(8)) b1_if ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .DISP_W(8)) b0_if ();

  assign b1_if.wr_en      = wr_en;
  assign b1_if.wr_addr    = wr_addr;
  assign b1_if.wr_data    = wr_data;
  assign b1_if.ld_wr_en   = ld_wr_en;
  assign b1_if.ld_wr_addr = ld_wr_addr;
  assign b1_if.ld_wr_data = ld_wr_data;
  assign b1_if.busy_set   = busy_set;
  assign b1_if.busy_addr  = busy_addr;
  assign b1_if.rs         = rs;
  assign b1_if.rt         = rt;
  assign b0_if.wr_en      = wr_en;
  assign b0_if.wr_addr    = wr_addr;
  assign b0_if.wr_data    = wr_data;
  assign b0_if.ld_wr_en   = ld_wr_en;
  assign b0_if.ld_wr_addr = ld_wr_addr;
  assign b0_if.ld_wr_data = ld_wr_data;
  assign b0_if.busy_set   = busy_set;
  assign b0_if.busy_addr  = busy_addr;
  assign b0_if.rs         = rs;
  assign b0_if.rt         = rt;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .DISP_REG(15), .DISP_W(8)) u_b1 (
    .clk (clk),
    .rst (rst),
    .bus (b1_if.slave)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .DISP_REG(15), .DISP_W(8)) u_b0 (
    .clk (clk),
    .rst (rst),
    .bus (b0_if.slave)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic logic [15:0] get_actual(input bit sel, input int field);
    logic [15:0] v;
    v = 16'hxxxx;
    if (sel) begin
      case (field)
        F_RS_DATA: v = b1_if.rs_data;
        F_RT_DATA: v = b1_if.rt_data;
        F_RS_BUSY: v = {15'd0, b1_if.rs_busy};
        F_RT_BUSY: v = {15'd0, b1_if.rt_busy};
        F_STALL:   v = {15'd0, b1_if.stall};
        F_COLL:    v = {15'd0, b1_if.wr_collide};
        F_DISP:    v = {8'd0, b1_if.disp};
        default:   v = 16'hxxxx;
      endcase
    end else begin
      case (field)
        F_RS_DATA: v = b0_if.rs_data;
        F_RT_DATA: v = b0_if.rt_data;
        F_RS_BUSY: v = {15'd0, b0_if.rs_busy};
        F_RT_BUSY: v = {15'd0, b0_if.rt_busy};
        F_STALL:   v = {15'd0, b0_if.stall};
        F_COLL:    v = {15'd0, b0_if.wr_collide};
        F_DISP:    v = {8'd0, b0_if.disp};
        default:   v = 16'hxxxx;
      endcase
    end
    return v;
  endfunction

  task automatic check_output(input exp_t e);
    logic [15:0] act;
    act = get_actual(e.sel, e.field);
    checks++;
    if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s (bypass=%0d): got %h expected %h", e.name, e.sel, act, e.val);
    end
  endtask

  task automatic expect_val(input bit sel, input int field, input logic [15:0] val,
                            input string name);
    exp_t e;
    e.sel   = sel;
    e.field = field;
    e.val   = val;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Advance to just after the next rising edge and drop all strobes
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    ld_wr_en = 1'b0;
    busy_set = 1'b0;
  endtask

  // Monitor: every falling edge drains whatever the stimulus queued this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        check_output(sb.pop_front());
      end
    end
  end

  initial begin
    $display("[TB] regfile_sb bench start");

    // Reset state
    rs = 4'd5;
    apply_stimulus();
    apply_stimulus();
    expect_val(1, F_RS_DATA, 16'h0000, "reset_rs");
    expect_val(0, F_RS_DATA, 16'h0000, "reset_rs");
    expect_val(1, F_STALL,   16'h0000, "reset_stall");
    expect_val(1, F_DISP,    16'h0000, "reset_disp");
    expect_val(1, F_COLL,    16'h0000, "reset_coll");
    apply_stimulus();
    rst = 1'b1;

    // Write r5 then reset mid-cycle
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rs = 4'd5;
    expect_val(1, F_RS_DATA, 16'hBEEF, "bypass_r5");
    expect_val(0, F_RS_DATA, 16'h0000, "nobypass_r5_old");
    apply_stimulus();
    expect_val(1, F_RS_DATA, 16'hBEEF, "r5_stored");
    expect_val(0, F_RS_DATA, 16'hBEEF, "r5_stored");
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h7777;
    #2 rst = 1'b0;
    expect_val(1, F_RS_DATA, 16'h0000, "midreset_rs");
    expect_val(0, F_RS_DATA, 16'h0000, "midreset_rs");
    expect_val(1, F_STALL,   16'h0000, "midreset_stall");
    expect_val(0, F_DISP,    16'h0000, "midreset_disp");
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h7777;
    expect_val(0, F_RS_DATA, 16'h0000, "reset_write_ignored");
    apply_stimulus();
    rst = 1'b1;
    expect_val(0, F_RS_DATA, 16'h0000, "post_reset_r5");
    expect_val(1, F_RS_DATA, 16'h0000, "post_reset_r5");

    // r0 hardwired
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
    busy_set = 1'b1; busy_addr = 4'd0; rs = 4'd0; rt = 4'd0;
    expect_val(1, F_RS_DATA, 16'h0000, "r0_bypass");
    expect_val(0, F_RS_DATA, 16'h0000, "r0_read");
    apply_stimulus();
    expect_val(1, F_RS_DATA, 16'h0000, "r0_after");
    expect_val(0, F_RS_DATA, 16'h0000, "r0_after");
    expect_val(1, F_RS_BUSY, 16'h0000, "r0_busy");
    expect_val(0, F_RS_BUSY, 16'h0000, "r0_busy");
    expect_val(0, F_STALL,   16'h0000, "r0_stall");

    // Dual-port collision on r3
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111;
    ld_wr_en = 1'b1; ld_wr_addr = 4'd3; ld_wr_data = 16'h2222; rs = 4'd3;
    expect_val(1, F_RS_DATA, 16'h2222, "collide_bypass");
    expect_val(0, F_RS_DATA, 16'h0000, "collide_nobypass_old");
    expect_val(1, F_COLL,    16'h0000, "collide_not_yet");
    apply_stimulus();
    rs = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd0; ld_wr_en = 1'b1; ld_wr_addr = 4'd0;
    expect_val(1, F_RS_DATA, 16'h2222, "collide_stored");
    expect_val(0, F_RS_DATA, 16'h2222, "collide_stored");
    expect_val(1, F_COLL,    16'h0001, "collide_pulse");
    expect_val(0, F_COLL,    16'h0001, "collide_pulse");
    apply_stimulus();
    expect_val(1, F_COLL,    16'h0000, "collide_one_cycle_r0");
    expect_val(0, F_COLL,    16'h0000, "collide_one_cycle_r0");

    // Scoreboard on r7
    apply_stimulus();
    busy_set = 1'b1; busy_addr = 4'd7; rt = 4'd7; rs = 4'd0;
    expect_val(1, F_RT_BUSY, 16'h0000, "busy_not_yet");
    apply_stimulus();
    expect_val(1, F_RT_BUSY, 16'h0001, "busy_set");
    expect_val(0, F_RT_BUSY, 16'h0001, "busy_set");
    expect_val(1, F_STALL,   16'h0001, "busy_stall");
    expect_val(0, F_STALL,   16'h0001, "busy_stall");
    apply_stimulus();
    ld_wr_en = 1'b1; ld_wr_addr = 4'd7; ld_wr_data = 16'h00AA;
    expect_val(1, F_RT_BUSY, 16'h0000, "load_hides_busy");
    expect_val(1, F_RT_DATA, 16'h00AA, "load_bypass");
    expect_val(1, F_STALL,   16'h0000, "load_no_stall");
    expect_val(0, F_RT_BUSY, 16'h0001, "load_busy_nobypass");
    expect_val(0, F_RT_DATA, 16'h0000, "load_old_nobypass");
    expect_val(0, F_STALL,   16'h0001, "load_stall_nobypass");
    apply_stimulus();
    expect_val(1, F_RT_BUSY, 16'h0000, "busy_cleared");
    expect_val(0, F_RT_BUSY, 16'h0000, "busy_cleared");
    expect_val(0, F_RT_DATA, 16'h00AA, "load_stored");
    expect_val(0, F_STALL,   16'h0000, "cleared_stall");
    apply_stimulus();
    busy_set = 1'b1; busy_addr = 4'd7;
    ld_wr_en = 1'b1; ld_wr_addr = 4'd7; ld_wr_data = 16'h00BB;
    expect_val(1, F_RT_DATA, 16'h00BB, "setclr_bypass");
    expect_val(1, F_RT_BUSY, 16'h0000, "setclr_busy_now");
    expect_val(0, F_RT_DATA, 16'h00AA, "setclr_old");
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0DDD; rs = 4'd7;
    expect_val(1, F_RT_BUSY, 16'h0001, "set_wins");
    expect_val(0, F_RT_BUSY, 16'h0001, "set_wins");
    expect_val(1, F_RS_BUSY, 16'h0001, "set_wins_rs");
    expect_val(1, F_STALL,   16'h0001, "set_wins_stall");
    expect_val(1, F_RT_DATA, 16'h0DDD, "porta_bypass_busy_reg");
    expect_val(0, F_RT_DATA, 16'h00BB, "setclr_stored");
    apply_stimulus();
    rs = 4'd0;
    expect_val(1, F_RT_BUSY, 16'h0001, "porta_keeps_busy");
    expect_val(0, F_RT_BUSY, 16'h0001, "porta_keeps_busy");
    expect_val(0, F_RT_DATA, 16'h0DDD, "porta_stored");
    apply_stimulus();
    ld_wr_en = 1'b1; ld_wr_addr = 4'd7; ld_wr_data = 16'h00CC;
    expect_val(1, F_RT_BUSY, 16'h0000, "second_load_hides");
    apply_stimulus();
    expect_val(1, F_RT_BUSY, 16'h0000, "second_load_clear");
    expect_val(0, F_RT_BUSY, 16'h0000, "second_load_clear");
    expect_val(0, F_RT_DATA, 16'h00CC, "second_load_stored");

    // Write latency without bypass
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555; rs = 4'd2; rt = 4'd0;
    expect_val(0, F_RS_DATA, 16'h0000, "nobypass_old");
    expect_val(1, F_RS_DATA, 16'h5555, "bypass_new");
    apply_stimulus();
    expect_val(0, F_RS_DATA, 16'h5555, "nobypass_next");
    expect_val(1, F_RS_DATA, 16'h5555, "bypass_next");

    // Display tap on r15
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hABCD;
    expect_val(1, F_DISP, 16'h0000, "disp_before");
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1357;
    expect_val(1, F_DISP, 16'h0000, "disp_lag");
    expect_val(0, F_DISP, 16'h0000, "disp_lag");
    apply_stimulus();
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h2468;
    expect_val(1, F_DISP, 16'h00CD, "disp_two_edges");
    expect_val(0, F_DISP, 16'h00CD, "disp_two_edges");
    apply_stimulus();
    expect_val(1, F_DISP, 16'h00CD, "disp_hold");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
